// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-select encoding, divider table helper,
// frame constants and receiver state encoding.
package uart_pkg;

    localparam logic [2:0] IDX_1200   = 3'd0;
    localparam logic [2:0] IDX_2400   = 3'd1;
    localparam logic [2:0] IDX_4800   = 3'd2;
    localparam logic [2:0] IDX_9600   = 3'd3;
    localparam logic [2:0] IDX_19200  = 3'd4;
    localparam logic [2:0] IDX_38400  = 3'd5;
    localparam logic [2:0] IDX_57600  = 3'd6;
    localparam logic [2:0] IDX_115200 = 3'd7;

    localparam int   DATA_BITS  = 8;
    localparam logic PARITY_ODD = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Bit-period counter limit (clock cycles per bit minus one).
    function automatic logic [31:0] div(input int unsigned freq, input logic [2:0] idx);
        int unsigned baud;
        case (idx)
            IDX_1200:  baud = 1200;
            IDX_2400:  baud = 2400;
            IDX_4800:  baud = 4800;
            IDX_9600:  baud = 9600;
            IDX_19200: baud = 19200;
            IDX_38400: baud = 38400;
            IDX_57600: baud = 57600;
            default:   baud = 115200;
        endcase
        return 32'(freq / baud - 1);
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the
// idle (high) level so reset never looks like a start bit.
module uart_sync2 (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, parity, 1 stop bit, with a one-entry
// valid/ready holding register and sticky parity/framing/overrun flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FREQ         = 50000000,
    parameter int CONFIG_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    output logic [7:0]              dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    input  logic [CONFIG_WIDTH-1:0] rx_conf,
    output logic                    parity_err,
    output logic                    frame_err,
    output logic                    overrun,
    input  logic                    clear
);

    localparam logic [31:0] LIM_TAB [8] = '{
        div(FREQ, IDX_1200),  div(FREQ, IDX_2400),  div(FREQ, IDX_4800),
        div(FREQ, IDX_9600),  div(FREQ, IDX_19200), div(FREQ, IDX_38400),
        div(FREQ, IDX_57600), div(FREQ, IDX_115200)
    };

    logic rx_s;

    uart_sync2 u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        mismatch_q, mismatch_d;
    logic [2:0]  idx_q, idx_d;
    logic        odd_q, odd_d;
    logic        armed_q, armed_d;
    logic [7:0]  dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;

    logic [31:0] limit;
    logic [31:0] mid;
    logic [2:0]  conf_idx;
    logic        sample;
    logic        perr_set, ferr_set, ovr_set;
    logic        unused_conf;

    assign conf_idx    = (rx_conf[31:16] > 16'd7) ? IDX_115200 : rx_conf[18:16];
    assign unused_conf = ^rx_conf[15:1];
    assign limit       = LIM_TAB[idx_q];
    assign mid         = limit >> 1;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        mismatch_d   = mismatch_q;
        idx_d        = idx_q;
        odd_d        = odd_q;
        armed_d      = armed_q | rx_s;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        sample       = 1'b0;
        perr_set     = 1'b0;
        ferr_set     = 1'b0;
        ovr_set      = 1'b0;

        if (dout_valid_q && dout_ready)
            dout_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                // armed_q blocks re-triggering on a line still held low after a break
                if (!rx_s && armed_q) begin
                    state_d = START;
                    idx_d   = conf_idx;
                    odd_d   = (rx_conf[0] == PARITY_ODD);
                end
            end
            START: begin
                if (cnt_q == mid) begin
                    sample    = 1'b1;
                    bit_cnt_d = 4'd0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == limit) begin
                    sample    = 1'b1;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1))
                        state_d = PARITY;
                end
            end
            PARITY: begin
                if (cnt_q == limit) begin
                    sample     = 1'b1;
                    mismatch_d = rx_s != (odd_q ? ~^shift_q : ^shift_q);
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (cnt_q == limit) begin
                    sample   = 1'b1;
                    state_d  = IDLE;
                    perr_set = mismatch_q;
                    ferr_set = !rx_s;
                    if (!rx_s)
                        armed_d = 1'b0;
                    if (!dout_valid_q || dout_ready) begin
                        dout_d       = shift_q;
                        dout_valid_d = 1'b1;
                    end else begin
                        ovr_set = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        cnt_d  = (sample || (state_d != state_q)) ? 32'd0 : cnt_q + 32'd1;
        // a same-cycle set overrides clear
        perr_d = (perr_q & ~clear) | perr_set;
        ferr_d = (ferr_q & ~clear) | ferr_set;
        ovr_d  = (ovr_q  & ~clear) | ovr_set;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 32'd0;
            bit_cnt_q    <= 4'd0;
            idx_q        <= IDX_115200;
            odd_q        <= 1'b0;
            armed_q      <= 1'b1;
            dout_q       <= 8'd0;
            dout_valid_q <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            idx_q        <= idx_d;
            odd_q        <= odd_d;
            armed_q      <= armed_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            ovr_q        <= ovr_d;
        end
    end

    always_ff @(posedge clock) begin
        shift_q    <= shift_d;
        mismatch_q <= mismatch_d;
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at FREQ=1152000 (index 7 -> 10 cycles per bit).
module tb_uart_rx;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] rx_conf;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        clear;

    uart_rx #(.FREQ(1152000), .CONFIG_WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .rx_conf    (rx_conf),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .clear      (clear)
    );

    always #5 clock = ~clock;

    int         cyc = 0;
    int         n_pulse = 0;
    logic [7:0] last_dout = 8'd0;
    int         last_cyc = 0;
    logic       vld_prev = 1'b0;
    int         start_cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Record each rising edge of dout_valid with the byte and cycle.
    always @(negedge clock) begin
        vld_prev <= dout_valid;
        if (dout_valid && !vld_prev) begin
            n_pulse   <= n_pulse + 1;
            last_dout <= dout;
            last_cyc  <= cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required < 2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_total++;
        if (act < lo || act > hi)
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] conf(input int idx, input logic odd);
        return {16'(idx), 15'd0, odd};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_clear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int bc);
        @(negedge clock);
        rx = 1'b0;
        start_cyc = cyc;
        idle(bc);
        for (int b = 0; b < 8; b++) begin
            rx = d[b];
            idle(bc);
        end
        rx = par;
        idle(bc);
        rx = stp;
        idle(bc);
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       odd;
        logic       par;
        logic       stp;
        logic [7:0] exp_dout;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];
    int   n0;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};

        reset      = 1'b1;
        rx         = 1'b1;
        dout_ready = 1'b1;
        clear      = 1'b0;
        rx_conf    = conf(7, 1'b0);
        idle(3);
        reset = 1'b0;
        idle(2);
        check("reset_dout", dout, 8'h00);
        check("reset_valid", dout_valid, 0);
        check("reset_perr", parity_err, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);

        for (int i = 0; i < 6; i++) begin
            rx_conf = conf(7, vecs[i].odd);
            pulse_clear();
            check($sformatf("v%0d_cleared_perr", i), parity_err, 0);
            check($sformatf("v%0d_cleared_ferr", i), frame_err, 0);
            n0 = n_pulse;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stp, 10);
            idle(5);
            check($sformatf("v%0d_pulses", i), n_pulse - n0, 1);
            check($sformatf("v%0d_dout", i), last_dout, vecs[i].exp_dout);
            check($sformatf("v%0d_valid_low", i), dout_valid, 0);
            check($sformatf("v%0d_perr", i), parity_err, vecs[i].exp_perr);
            check($sformatf("v%0d_ferr", i), frame_err, vecs[i].exp_ferr);
            check($sformatf("v%0d_ovr", i), overrun, 0);
            if (i == 0)
                check_range("latency", last_cyc - start_cyc, 106, 110);
        end

        // Overrun: consumer stalled across two frames.
        rx_conf = conf(7, 1'b0);
        pulse_clear();
        dout_ready = 1'b0;
        n0 = n_pulse;
        send_frame(8'h11, 1'b0, 1'b1, 10);
        idle(5);
        check("ovr_first_pulse", n_pulse - n0, 1);
        check("ovr_first_dout", dout, 8'h11);
        check("ovr_first_valid", dout_valid, 1);
        send_frame(8'h22, 1'b0, 1'b1, 10);
        idle(5);
        check("ovr_dout_held", dout, 8'h11);
        check("ovr_valid_held", dout_valid, 1);
        check("ovr_flag", overrun, 1);
        dout_ready = 1'b1;
        @(negedge clock);
        check("ovr_accept_valid", dout_valid, 0);
        check("ovr_accept_dout", last_dout, 8'h11);

        // Glitch in IDLE is rejected, then a 9600-baud frame.
        pulse_clear();
        n0 = n_pulse;
        @(negedge clock);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(30);
        check("glitch_no_byte", n_pulse - n0, 0);
        check("glitch_no_ferr", frame_err, 0);
        check("glitch_no_perr", parity_err, 0);
        rx_conf = conf(3, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b1, 120);
        idle(5);
        check("b9600_pulse", n_pulse - n0, 1);
        check("b9600_dout", last_dout, 8'hF0);
        check("b9600_flags", {parity_err, frame_err, overrun}, 0);

        // Reset mid-frame with a held byte and a set flag.
        rx_conf = conf(7, 1'b0);
        dout_ready = 1'b0;
        send_frame(8'h33, 1'b0, 1'b0, 10);
        idle(5);
        check("pre_reset_valid", dout_valid, 1);
        check("pre_reset_ferr", frame_err, 1);
        n0 = n_pulse;
        @(negedge clock);
        rx = 1'b0;
        idle(10);
        for (int b = 0; b < 4; b++) begin
            rx = b[0] ? 1'b1 : 1'b0;
            idle(10);
        end
        rx = 1'b1;
        idle(5);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(1);
        check("midrst_dout", dout, 8'h00);
        check("midrst_valid", dout_valid, 0);
        check("midrst_flags", {parity_err, frame_err, overrun}, 0);
        dout_ready = 1'b1;
        idle(150);
        check("midrst_no_partial", n_pulse - n0, 0);
        send_frame(8'h7E, 1'b0, 1'b1, 10);
        idle(5);
        check("after_rst_pulse", n_pulse - n0, 1);
        check("after_rst_dout", last_dout, 8'h7E);
        check("after_rst_flags", {parity_err, frame_err, overrun}, 0);

        // Break: line held low.
        n0 = n_pulse;
        @(negedge clock);
        rx = 1'b0;
        idle(150);
        check("break_pulse", n_pulse - n0, 1);
        check("break_dout", last_dout, 8'h00);
        check("break_ferr", frame_err, 1);
        check("break_perr", parity_err, 0);
        idle(150);
        check("break_no_retrigger", n_pulse - n0, 1);
        rx = 1'b1;
        idle(5);
        pulse_clear();
        send_frame(8'h5A, 1'b0, 1'b1, 10);
        idle(5);
        check("post_break_pulse", n_pulse - n0, 2);
        check("post_break_dout", last_dout, 8'h5A);
        check("post_break_ferr", frame_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
